pc_sequencer: RTL and testbench

Parametrised successor to the single-cycle program counter, used as the fetch-address generator for the pipelined core. Holds the PC and produces the instruction-memory address under a valid/ready fetch handshake. Selects the next PC from sequential increment, branch/jump redirect, return-address-stack pop or exception vector, by fixed priority. Contains a small return-address stack (RAS) and a boot/exception-entry FSM.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_ras_stack.sv | 71 +++++++
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-address sequencer.
package pc_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXC  = 2'd2
    } pc_state_e;

    // Next-PC source chosen in RUN, listed from highest to lowest priority
    typedef enum logic [2:0] {
        SEL_EXC       = 3'd0,
        SEL_MISALIGN  = 3'd1,
        SEL_REDIRECT  = 3'd2,
        SEL_UNDERFLOW = 3'd3,
        SEL_RAS       = 3'd4,
        SEL_SEQ       = 3'd5,
        SEL_HOLD      = 3'd6
    } npc_sel_e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack with a saturating entry count.
module pc_ras_stack #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [PC_WIDTH-1:0]           push_addr_i,
    input  logic                          pop_i,
    output logic [PC_WIDTH-1:0]           top_o,
    output logic                          empty_o,
    output logic [$clog2(RAS_DEPTH):0]    count_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr_q, ptr_d, wr_ptr;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                empty_q, empty_d;
    logic                wr_en;

    // Pointer/count update; push+pop replaces the top entry in place
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_ptr  = ptr_q;
        if (push_i && pop_i) begin
            wr_en  = 1'b1;
        end else if (push_i) begin
            ptr_d  = ptr_q + PTR_W'(1);
            wr_en  = 1'b1;
            wr_ptr = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
        empty_d = (cnt_d == '0);
    end

    // Control registers; storage contents are meaningless while count is zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= push_addr_i;
        end
    end

    assign top_o   = mem_q[ptr_q];
    assign empty_o = empty_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: PC register, next-PC priority select, boot/exception FSM.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INSTR_BYTES = 4,
    parameter int unsigned          RAS_DEPTH   = 4,
    parameter logic [PC_WIDTH-1:0]  EXC_VECTOR  = PC_WIDTH'(EXC_VECTOR_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic                 fetch_ready,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_target,
    input  logic                 ras_push,
    input  logic [PC_WIDTH-1:0]  ras_push_addr,
    input  logic                 ras_pop,
    input  logic                 exception,
    output logic [PC_WIDTH-1:0]  address,
    output logic                 fetch_valid,
    output logic                 misaligned,
    output logic                 ras_underflow,
    output logic                 ras_empty
);

    localparam int unsigned         CNT_W      = $clog2(RAS_DEPTH) + 1;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(INSTR_BYTES);

    pc_state_e           state_q, state_d;
    npc_sel_e            sel;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic                fv_q, fv_d;
    logic                mis_q, mis_d;
    logic                und_q, und_d;
    logic                push_en, pop_en;
    logic [PC_WIDTH-1:0] ras_top;
    logic [CNT_W-1:0]    ras_cnt;
    logic                ras_empty_w;

    pc_ras_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push_en),
        .push_addr_i (ras_push_addr),
        .pop_i       (pop_en),
        .top_o       (ras_top),
        .empty_o     (ras_empty_w),
        .count_o     (ras_cnt)
    );

    // Next-state, next-PC and pulse generation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel     = SEL_HOLD;
        mis_d   = 1'b0;
        und_d   = 1'b0;
        push_en = 1'b0;
        pop_en  = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_EXC: begin
                addr_d  = EXC_VECTOR;
                state_d = exception ? ST_EXC : ST_RUN;
            end
            ST_RUN: begin
                push_en = ras_push;
                if (exception)                                              sel = SEL_EXC;
                else if (redirect_valid && ((redirect_target & ALIGN_MASK) != '0)) sel = SEL_MISALIGN;
                else if (redirect_valid)                                    sel = SEL_REDIRECT;
                else if (ras_pop && (ras_cnt == '0))                        sel = SEL_UNDERFLOW;
                else if (ras_pop)                                           sel = SEL_RAS;
                else if (fetch_ready)                                       sel = SEL_SEQ;
                else                                                        sel = SEL_HOLD;
                case (sel)
                    SEL_EXC: begin
                        addr_d  = EXC_VECTOR;
                        state_d = ST_EXC;
                    end
                    SEL_MISALIGN: begin
                        addr_d  = EXC_VECTOR;
                        state_d = ST_EXC;
                        mis_d   = 1'b1;
                    end
                    SEL_REDIRECT:  addr_d = redirect_target;
                    SEL_UNDERFLOW: begin
                        addr_d  = EXC_VECTOR;
                        state_d = ST_EXC;
                        und_d   = 1'b1;
                    end
                    SEL_RAS: begin
                        addr_d = ras_top;
                        pop_en = 1'b1;
                    end
                    SEL_SEQ:  addr_d = addr_q + PC_INC;
                    default:  addr_d = addr_q;
                endcase
            end
            default: state_d = ST_BOOT;
        endcase
        fv_d = (state_d == ST_RUN);
    end

    // State and output registers; address reloads start_pc while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            addr_q  <= start_pc;
            fv_q    <= 1'b0;
            mis_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fv_q    <= fv_d;
            mis_q   <= mis_d;
            und_q   <= und_d;
        end
    end

    assign address       = addr_q;
    assign fetch_valid   = fv_q;
    assign misaligned    = mis_q;
    assign ras_underflow = und_q;
    assign ras_empty     = ras_empty_w;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] start_pc;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic        exception;
    logic [31:0] address;
    logic        fetch_valid;
    logic        misaligned;
    logic        ras_underflow;
    logic        ras_empty;

    int n_chk  = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start_pc        (start_pc),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ras_push        (ras_push),
        .ras_push_addr   (ras_push_addr),
        .ras_pop         (ras_pop),
        .exception       (exception),
        .address         (address),
        .fetch_valid     (fetch_valid),
        .misaligned      (misaligned),
        .ras_underflow   (ras_underflow),
        .ras_empty       (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start_pc = 32'h0040_0000;
        fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0; exception = 1'b0;
        #23;
        n_chk++; if (address !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", address, 32'h0040_0000); end
        n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b expected 0", fetch_valid); end
        n_chk++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", ras_empty); end
        n_chk++; if ({misaligned, ras_underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {misaligned, ras_underflow}); end
        fetch_ready = 1'b1;
        reset = 1'b1;
        #1;
        n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot_fv: got %b expected 0", fetch_valid); end
    endtask

    task automatic test_sequential();
        tick();
        n_chk++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv: got %b expected 1", fetch_valid); end
        n_chk++; if (address !== 32'h0040_0000) begin n_fail++; $display("FAIL seq0: got %h expected %h", address, 32'h0040_0000); end
        tick();
        n_chk++; if (address !== 32'h0040_0004) begin n_fail++; $display("FAIL seq1: got %h expected %h", address, 32'h0040_0004); end
        tick();
        n_chk++; if (address !== 32'h0040_0008) begin n_fail++; $display("FAIL seq2: got %h expected %h", address, 32'h0040_0008); end
    endtask

    task automatic test_stall_redirect();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (address !== 32'h0040_0008 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d: got %h/%b expected %h/1", i, address, fetch_valid, 32'h0040_0008); end
        end
        redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
        tick();
        redirect_valid = 1'b0;
        n_chk++; if (address !== 32'h0040_0100) begin n_fail++; $display("FAIL stall_redirect: got %h expected %h", address, 32'h0040_0100); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_target = 32'h0040_0102;
        tick();
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        n_chk++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b expected 1", misaligned); end
        n_chk++; if (address !== 32'h0000_0180 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL mis_exc: got %h/%b expected 00000180/0", address, fetch_valid); end
        tick();
        n_chk++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %b expected 0", misaligned); end
        n_chk++; if (address !== 32'h0000_0180 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL mis_vec_fetch: got %h/%b expected 00000180/1", address, fetch_valid); end
        tick();
        n_chk++; if (address !== 32'h0000_0184) begin n_fail++; $display("FAIL mis_vec_next: got %h expected %h", address, 32'h0000_0184); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_pop [4];
        exp_pop = '{32'h0000_5000, 32'h0000_4000, 32'h0000_3000, 32'h0000_2000};
        fetch_ready = 1'b0;
        ras_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ras_push_addr = 32'h0000_1000 * (i + 1);
            tick();
        end
        ras_push = 1'b0;
        n_chk++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL ras_nonempty: got %b expected 0", ras_empty); end
        ras_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (address !== exp_pop[i]) begin n_fail++; $display("FAIL ras_pop%0d: got %h expected %h", i, address, exp_pop[i]); end
        end
        tick();
        ras_pop = 1'b0;
        n_chk++; if (ras_underflow !== 1'b1) begin n_fail++; $display("FAIL ras_underflow: got %b expected 1", ras_underflow); end
        n_chk++; if (address !== 32'h0000_0180 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL underflow_exc: got %h/%b expected 00000180/0", address, fetch_valid); end
        n_chk++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ras_empty_after: got %b expected 1", ras_empty); end
        tick();
        n_chk++; if (ras_underflow !== 1'b0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL underflow_recover: got %b/%b expected 0/1", ras_underflow, fetch_valid); end
    endtask

    task automatic test_same_cycle();
        fetch_ready = 1'b0;
        ras_push = 1'b1; ras_push_addr = 32'h0000_7000;
        tick();
        ras_push = 1'b0;
        exception = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_8000; ras_pop = 1'b1;
        tick();
        redirect_valid = 1'b0; ras_pop = 1'b0;
        n_chk++; if (address !== 32'h0000_0180 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL exc_wins: got %h/%b expected 00000180/0", address, fetch_valid); end
        n_chk++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL exc_keeps_ras: got %b expected 0", ras_empty); end
        tick();
        exception = 1'b0;
        n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL exc_held: got %b expected 0", fetch_valid); end
        tick();
        n_chk++; if (address !== 32'h0000_0180 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL exc_return: got %h/%b expected 00000180/1", address, fetch_valid); end
        ras_push = 1'b1; ras_push_addr = 32'h0000_9000; ras_pop = 1'b1;
        tick();
        ras_push = 1'b0;
        n_chk++; if (address !== 32'h0000_7000) begin n_fail++; $display("FAIL pushpop_old_top: got %h expected %h", address, 32'h0000_7000); end
        n_chk++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL pushpop_count: got %b expected 0", ras_empty); end
        tick();
        ras_pop = 1'b0;
        n_chk++; if (address !== 32'h0000_9000) begin n_fail++; $display("FAIL pushpop_new_top: got %h expected %h", address, 32'h0000_9000); end
        n_chk++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL pushpop_drained: got %b expected 1", ras_empty); end
    endtask

    task automatic test_wrap_and_reset();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        n_chk++; if (address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h expected %h", address, 32'hFFFF_FFFC); end
        tick();
        n_chk++; if (address !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 00000000", address); end
        tick();
        n_chk++; if (address !== 32'h0000_0004) begin n_fail++; $display("FAIL wrap_next: got %h expected 00000004", address); end
        start_pc = 32'h0040_0000;
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (address !== 32'h0040_0000) begin n_fail++; $display("FAIL async_reset_addr: got %h expected %h", address, 32'h0040_0000); end
        n_chk++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_fv: got %b expected 0", fetch_valid); end
        #10;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_misaligned();
        test_ras_overflow();
        test_same_cycle();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
